// File: rtl/axil_ic_pkg.sv
// Shared types and constants for the AXI-Lite interconnect write/read port arbiters.
package axil_ic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR_DATA,
    RESP,
    TOERR
  } wr_port_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

endpackage

// File: rtl/axil_rr_select.sv
// Combinational winner selection: fixed priority (lowest index) or round robin after ptr.
module axil_rr_select #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic            rr_mode,
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    winner_onehot,
  output logic [IdxW-1:0] winner_idx,
  output logic            winner_valid
);

  int cand;

  always_comb begin
    winner_idx   = '0;
    winner_valid = 1'b0;
    cand         = 0;
    if (rr_mode) begin
      // Descending scan so the candidate closest after ptr is the last (winning) assignment.
      for (int k = int'(N); k >= 1; k--) begin
        cand = (int'(ptr) + k) % int'(N);
        if (req[cand]) begin
          winner_idx   = IdxW'(cand);
          winner_valid = 1'b1;
        end
      end
    end else begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (req[i]) begin
          winner_idx   = IdxW'(i);
          winner_valid = 1'b1;
        end
      end
    end
    winner_onehot = winner_valid ? (N'(1) << winner_idx) : '0;
  end

endmodule

// File: rtl/axil_wr_port_arbiter.sv
// Per-slave AXI-Lite write arbiter/mux; grant held from AW/W issue through the B handshake.
// Optional B-response timeout returning SLVERR is enabled by defining AXIL_WR_TIMEOUT_EN.
module axil_wr_port_arbiter
  import axil_ic_pkg::*;
#(
  parameter int unsigned NUMBER_MASTER  = 2,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned ARB_MODE       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned IdxW  = $clog2(NUMBER_MASTER),
  localparam int unsigned StrbW = AXI_DATA_WIDTH / 8
) (
  input  logic                                    aclk,
  input  logic                                    aresetn,
  input  logic [NUMBER_MASTER-1:0]                request_wr,
  input  logic [NUMBER_MASTER*AXI_ADDR_WIDTH-1:0] m_axil_awaddr,
  input  logic [NUMBER_MASTER-1:0]                m_axil_awvalid,
  output logic [NUMBER_MASTER-1:0]                m_axil_awready,
  input  logic [NUMBER_MASTER*AXI_DATA_WIDTH-1:0] m_axil_wdata,
  input  logic [NUMBER_MASTER*StrbW-1:0]          m_axil_wstrb,
  input  logic [NUMBER_MASTER-1:0]                m_axil_wvalid,
  output logic [NUMBER_MASTER-1:0]                m_axil_wready,
  output logic [NUMBER_MASTER*2-1:0]              m_axil_bresp,
  output logic [NUMBER_MASTER-1:0]                m_axil_bvalid,
  input  logic [NUMBER_MASTER-1:0]                m_axil_bready,
  output logic [AXI_ADDR_WIDTH-1:0]               s_axil_awaddr,
  output logic                                    s_axil_awvalid,
  input  logic                                    s_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0]               s_axil_wdata,
  output logic [StrbW-1:0]                        s_axil_wstrb,
  output logic                                    s_axil_wvalid,
  input  logic                                    s_axil_wready,
  input  logic [1:0]                              s_axil_bresp,
  input  logic                                    s_axil_bvalid,
  output logic                                    s_axil_bready,
  output logic [NUMBER_MASTER-1:0]                grant_wr,
  output logic [IdxW-1:0]                         grant_wr_cdr,
  output logic                                    busy
);

  wr_port_state_t state_q, state_d;
  logic [NUMBER_MASTER-1:0] grant_q, grant_d;
  logic [IdxW-1:0]          gidx_q, gidx_d;
  logic [IdxW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;

  logic [NUMBER_MASTER-1:0] req;
  logic [NUMBER_MASTER-1:0] win_onehot;
  logic [IdxW-1:0]          win_idx;
  logic                     win_valid;
  logic                     aw_hs, w_hs, b_hs;

`ifdef AXIL_WR_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES);

  logic [TimerW-1:0] timer_q, timer_d, timer_inc;
`endif

  assign req = request_wr & m_axil_awvalid;

  axil_rr_select #(
    .N   (NUMBER_MASTER),
    .IdxW(IdxW)
  ) u_select (
    .rr_mode      (ARB_MODE == ARB_RR),
    .req          (req),
    .ptr          (rr_ptr_q),
    .winner_onehot(win_onehot),
    .winner_idx   (win_idx),
    .winner_valid (win_valid)
  );

  // Datapath mux: only the granted master is connected, everything else reads as zero.
  always_comb begin
    s_axil_awaddr  = '0;
    s_axil_awvalid = 1'b0;
    s_axil_wdata   = '0;
    s_axil_wstrb   = '0;
    s_axil_wvalid  = 1'b0;
    s_axil_bready  = 1'b0;
    m_axil_awready = '0;
    m_axil_wready  = '0;
    m_axil_bvalid  = '0;
    m_axil_bresp   = '0;
    unique case (state_q)
      ADDR_DATA: begin
        s_axil_awaddr          = m_axil_awaddr[gidx_q*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        s_axil_wdata           = m_axil_wdata[gidx_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        s_axil_wstrb           = m_axil_wstrb[gidx_q*StrbW +: StrbW];
        s_axil_awvalid         = m_axil_awvalid[gidx_q] & ~aw_done_q;
        s_axil_wvalid          = m_axil_wvalid[gidx_q] & ~w_done_q;
        m_axil_awready[gidx_q] = s_axil_awready & ~aw_done_q;
        m_axil_wready[gidx_q]  = s_axil_wready & ~w_done_q;
      end
      RESP: begin
        m_axil_bvalid[gidx_q]       = s_axil_bvalid;
        m_axil_bresp[gidx_q*2 +: 2] = s_axil_bresp;
        s_axil_bready               = m_axil_bready[gidx_q];
      end
`ifdef AXIL_WR_TIMEOUT_EN
      TOERR: begin
        m_axil_bvalid[gidx_q]       = 1'b1;
        m_axil_bresp[gidx_q*2 +: 2] = RESP_SLVERR;
        s_axil_bready               = 1'b1;
      end
      IDLE: begin
        // Drain stray responses from a slave that answered after the timeout.
        s_axil_bready = aresetn;
      end
`endif
      default: ;
    endcase
  end

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;
  assign b_hs  = s_axil_bvalid & s_axil_bready;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_ptr_d  = rr_ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef AXIL_WR_TIMEOUT_EN
    timer_d   = timer_q;
    timer_inc = (timer_q == TimerMax) ? timer_q : timer_q + 1'b1;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d  = ADDR_DATA;
          grant_d  = win_onehot;
          gidx_d   = win_idx;
          rr_ptr_d = win_idx;
        end
      end
      ADDR_DATA: begin
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d   = RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef AXIL_WR_TIMEOUT_EN
          timer_d   = '0;
`endif
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      RESP: begin
        if (b_hs) begin
          state_d = IDLE;
          grant_d = '0;
          gidx_d  = '0;
        end
`ifdef AXIL_WR_TIMEOUT_EN
        else begin
          timer_d = timer_inc;
          // A real response presented on the limit cycle takes precedence.
          if (timer_inc == TimerMax && !s_axil_bvalid) begin
            state_d = TOERR;
          end
        end
`endif
      end
`ifdef AXIL_WR_TIMEOUT_EN
      TOERR: begin
        if (m_axil_bready[gidx_q]) begin
          state_d = IDLE;
          grant_d = '0;
          gidx_d  = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = '0;
        gidx_d  = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= IdxW'(NUMBER_MASTER - 1);
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      rr_ptr_q  <= rr_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef AXIL_WR_TIMEOUT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  assign grant_wr     = grant_q;
  assign grant_wr_cdr = gidx_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/axil_wr_port_arbiter.md
Name: axil_wr_port_arbiter

Overview:
- Per-slave write-path arbiter and multiplexer for the AXI-Lite interconnect: NUMBER_MASTER write channels (AW/W/B) into one slave port.
- Selectable fixed-priority or round-robin arbitration.
- Grant is held from AW/W issue until the B handshake completes.
- Optional response timeout that returns SLVERR.
- Instantiated once per slave by the next-generation interconnect; fed by the existing address decoders.

Parameters:
- NUMBER_MASTER, 2, number of upstream masters (>=2).
- AXI_DATA_WIDTH, 32, data width; strobe width is AXI_DATA_WIDTH/8.
- AXI_ADDR_WIDTH, 32, address width.
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round robin.
- TIMEOUT_CYCLES, 1024, B-wait limit; used only with AXIL_WR_TIMEOUT_EN; >=1.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- request_wr  in  NUMBER_MASTER  decoder hit for this slave, per master.
- m_axil_awaddr  in  AXI_ADDR_WIDTH x NUMBER_MASTER  master write addresses.
- m_axil_awvalid / m_axil_awready  in/out  NUMBER_MASTER  AW handshake.
- m_axil_wdata  in  AXI_DATA_WIDTH x NUMBER_MASTER  write data.
- m_axil_wstrb  in  AXI_DATA_WIDTH/8 x NUMBER_MASTER  byte strobes.
- m_axil_wvalid / m_axil_wready  in/out  NUMBER_MASTER  W handshake.
- m_axil_bresp  out  2 x NUMBER_MASTER  response.
- m_axil_bvalid / m_axil_bready  out/in  NUMBER_MASTER  B handshake.
- s_axil_awaddr / s_axil_awvalid / s_axil_awready  out/out/in  AXI_ADDR_WIDTH/1/1  slave AW.
- s_axil_wdata / s_axil_wstrb / s_axil_wvalid / s_axil_wready  out/out/out/in  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1/1  slave W.
- s_axil_bresp / s_axil_bvalid / s_axil_bready  in/in/out  2/1/1  slave B.
- grant_wr  out  NUMBER_MASTER  one-hot current grant.
- grant_wr_cdr  out  $clog2(NUMBER_MASTER)  encoded grant.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, aresetn low): state IDLE; grant_wr = 0; grant_wr_cdr = 0; aw_done = w_done = 0; rr pointer = NUMBER_MASTER-1, so master 0 wins first. All valid/ready outputs are 0 and data outputs are 0. Reset mid-transaction abandons it with no B issued.
- IDLE:
  - Requesters are masters with request_wr[i] & m_axil_awvalid[i].
  - ARB_MODE 0: lowest index wins. ARB_MODE 1: first requester after the pointer, wrapping at NUMBER_MASTER-1 -> 0.
  - Grant is registered: one cycle of arbitration latency, then ADDR_DATA. The pointer updates to the winner at grant.
  - No requester: stay in IDLE.
- ADDR_DATA:
  - Muxed master g drives the slave. s_axil_awvalid = m_axil_awvalid[g] & !aw_done; s_axil_wvalid = m_axil_wvalid[g] & !w_done.
  - m_axil_awready[g] and m_axil_wready[g] mirror the slave readies gated by the same flags.
  - AW and W complete independently and in either order; aw_done / w_done set on their handshakes.
  - Both handshakes in the same cycle are legal.
  - When both are done (or complete this cycle), go to RESP and clear the flags.
- RESP:
  - m_axil_bvalid[g] = s_axil_bvalid; m_axil_bresp[g] = s_axil_bresp; s_axil_bready = m_axil_bready[g]. This is combinational pass-through.
  - On s_axil_bvalid & s_axil_bready: go to IDLE and clear grant_wr. New arbitration starts the following cycle.
- Non-granted masters always see ready/valid = 0 and bresp = 0.
- Request changes during a held grant are ignored.
- The slave always sees at most one outstanding write.

Optional Feature:
- Macro: AXIL_WR_TIMEOUT_EN.
- Enabled:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits runs in RESP.
  - It resets on entering RESP and saturates, so there is no wrap.
  - When the count reaches TIMEOUT_CYCLES without s_axil_bvalid, go to TOERR: m_axil_bvalid[g] = 1, m_axil_bresp[g] = 2'b10, held until m_axil_bready[g], then IDLE.
  - In IDLE and TOERR, s_axil_bready = 1, so late slave responses are silently consumed.
  - If s_axil_bvalid arrives in the same cycle the limit is reached, the real response wins.
- Disabled: no counter and no TOERR state; RESP waits indefinitely; s_axil_bready = 0 outside RESP.

Decomposition:
- Package axil_ic_pkg holds:
  - typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP, TOERR} wr_port_state_t
  - constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - ARB_FIXED = 0, ARB_RR = 1
- One sub-module, axil_rr_select: combinational request/pointer -> one-hot and encoded winner, with a mode input. It is reused later by the read-path arbiter.

Test Plan:
- Single write, NUMBER_MASTER=2, ARB_MODE=1: m1 request, awaddr 0x10, wdata 0xDEADBEEF, wstrb 0xF -> grant_wr = 2'b10 one cycle later; slave sees the same values; bresp OKAY returned only on m1; busy drops after B.
- Contention, round robin: m0 and m1 request continuously for 4 writes -> grant order 0,1,0,1. With ARB_MODE=0 -> 0,0,0,0.
- W before AW: master asserts wvalid 3 cycles before awvalid; slave holds awready low 2 cycles -> each handshake occurs exactly once; RESP entered only after both.
- Backpressure on B: slave bvalid with bresp 2'b10, master bready low 5 cycles -> bvalid and bresp held stable; grant held; new request from the other master is not served until the B handshake.
- Timeout (AXIL_WR_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never asserts bvalid -> after 8 RESP cycles master gets bresp 2'b10. A late slave bvalid in IDLE is consumed (s_axil_bready = 1) and not forwarded.
- Async reset asserted in ADDR_DATA after AW done -> all outputs 0 immediately. After release, master 0 wins the first arbitration.
